mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped 32-bit timer/compare peripheral on the core's data bus, alongside the data RAM. It decodes `daddr`, accepts full-word stores from `MemWrite`, returns register contents on `MemRead`, counts while enabled, and raises a level interrupt when the count matches a programmed compare value. The top level routes `rdata` to the core's `ddata_r` whenever `hit` is high; otherwise the RAM output is used.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: 32-byte-aligned base of the register window, above the 4 KB RAM span.
- `WIDTH`, 32: counter, compare and data width.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: reset is synchronous and active-low.
- `daddr` in 32: core data address.
- `ddata_w` in 32: core store data.
- `MemWrite` in 1: store strobe, single cycle.
- `MemRead` in 1: load strobe.
- `rdata` out 32: read data; 0 when `hit` is low.
- `hit` out 1: `daddr[31:5] == BASE_ADDR[31:5]`, combinational.
- `irq` out 1: `STATUS.MATCH & CTRL.IRQ_EN`, combinational from registers.

## Operation
- Register offsets use `daddr[4:2]`:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 COUNT: read/write.
  - 0x08 COMPARE: read/write.
  - 0x0C STATUS: bit0 MATCH; writing 1 clears it, writing 0 has no effect.
  - 0x10 PRESC: only with the macro; see Configuration.
- Unmapped offsets (0x14–0x1C) read 0; writes to them are ignored. Only full-word access is supported, and `daddr[1:0]` is ignored.
- Reads are combinational: `rdata` = selected register when `hit & MemRead`, else 0.
- A tick occurs every cycle while EN=1 (without the macro).
- On a tick where COUNT == COMPARE:
  - MATCH is set.
  - COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
- On a tick without a match, COUNT becomes COUNT+1, wrapping from 32'hFFFF_FFFF to 0 with no flag.
- Priorities for a single cycle:
  - A software write to COUNT overrides the tick update.
  - If a MATCH set and a STATUS write-1-clear occur together, the set wins.
  - A write to CTRL takes effect from the next cycle; the tick in the write cycle uses the old EN.
  - A COMPARE write in the same cycle as a match check uses the old COMPARE.

## Timing
- Reset: when `RESET_N`=0 at a rising edge, CTRL, COUNT, COMPARE, STATUS and PRESC are all cleared to 0.
  - Therefore `irq`=0 from the following edge.
  - `rdata`/`hit` are combinational and depend only on the bus inputs.
- Reset mid-count overrides any simultaneous write or tick.
- Write latency: register value is visible on `rdata` the cycle after the `MemWrite` edge.
- COUNT sequence: with EN set at edge N, COUNT reads 1 after edge N+1.
- Match to irq: if the match is detected at edge M, MATCH=1 and `irq`=1 (with IRQ_EN) right after edge M.
- Clear to irq: a STATUS write at edge C drops `irq` right after C, unless a new match occurs at C.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - Adds the 32-bit PRESC register at 0x10 and an internal prescale counter.
  - A tick occurs when EN=1 and the prescale counter equals PRESC. The prescale counter then resets to 0; otherwise it increments.
  - PRESC=0 gives a tick every cycle. PRESC=k gives a tick every k+1 cycles.
  - The prescale counter clears whenever EN=0 or PRESC is written.
- Not defined: no PRESC register, offset 0x10 reads 0, and a tick occurs every enabled cycle.

## Test plan
- Reset: apply `RESET_N`=0 for 2 cycles, then read all offsets → all 0, `irq`=0. Read at `daddr`=0x0000_0FFC → `hit`=0, `rdata`=0.
- Free run: write COUNT=0, then CTRL=0x1, wait 10 cycles → COUNT reads 10 (±bus-access cycles, checked against a reference model). MATCH=0 with COMPARE=0xFFFF_FFFF.
- Auto-reload: COMPARE=5, CTRL=0x7 → MATCH and `irq` assert on the edge after COUNT=5, and COUNT returns to 0. Write STATUS=1 → `irq`=0 the next cycle.
- Wrap: COUNT=0xFFFF_FFFE, COMPARE=3, CTRL=0x1 → COUNT goes …FFFF, 0, 1, 2, 3, 4; MATCH sets only on the 3→4 tick.
- Collisions:
  - A STATUS clear written in the match cycle → MATCH stays 1.
  - A COUNT write of 100 in a tick cycle → COUNT=100, not incremented.
- Prescaler (macro on): PRESC=3, CTRL=0x1 → COUNT increments every 4 cycles; 0x10 reads 3. Macro off: 0x10 reads 0.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer/compare peripheral with a level interrupt on COUNT == COMPARE.
// Optional prescaler register at offset 0x10 is built when TIMER_PRESCALER_EN is defined.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          WIDTH     = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [31:0]      daddr,
    input  logic [WIDTH-1:0] ddata_w,
    input  logic             MemWrite,
    input  logic             MemRead,
    output logic [WIDTH-1:0] rdata,
    output logic             hit,
    output logic             irq
);

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_PRESC   = 3'd4;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Bus: MemWrite/MemRead are single-cycle strobes with no back-pressure;
    // a store is committed on the rising edge it is sampled, loads are combinational.
    logic [2:0] reg_off;
    logic       wr_en;
    logic       wr_ctrl;
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       unused_addr_bits;

    logic             ctrl_en;
    logic             ctrl_auto_reload;
    logic             ctrl_irq_en;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] compare_q;
    logic             status_match;

    logic             tick;
    logic             match_now;
    logic [WIDTH-1:0] count_next;

    assign reg_off          = daddr[4:2];
    assign unused_addr_bits = ^daddr[1:0];
    assign hit              = (daddr[31:5] == BASE_ADDR[31:5]);
    assign wr_en            = hit & MemWrite;
    assign wr_ctrl          = wr_en && (reg_off == OFF_CTRL);
    assign wr_count         = wr_en && (reg_off == OFF_COUNT);
    assign wr_compare       = wr_en && (reg_off == OFF_COMPARE);
    assign wr_status        = wr_en && (reg_off == OFF_STATUS);

`ifdef TIMER_PRESCALER_EN
    logic             wr_presc;
    logic [WIDTH-1:0] presc_q;
    logic [WIDTH-1:0] presc_cnt_q;

    assign wr_presc = wr_en && (reg_off == OFF_PRESC);
    assign tick     = ctrl_en && (presc_cnt_q == presc_q);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            presc_q <= '0;
        end else if (wr_presc) begin
            presc_q <= ddata_w;
        end
    end

    // Prescale counter restarts on disable or reprogramming so the first tick is a full period away.
    always_ff @(posedge CLK) begin
        if (!RESET_N || !ctrl_en || wr_presc) begin
            presc_cnt_q <= '0;
        end else if (tick) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + ONE;
        end
    end
`else
    assign tick = ctrl_en;
`endif

    // Match check and tick use the pre-write COMPARE and EN values of this cycle.
    assign match_now = tick && (count_q == compare_q);

    always_comb begin
        count_next = count_q;
        if (wr_count) begin
            count_next = ddata_w;
        end else if (tick) begin
            if (match_now && ctrl_auto_reload) begin
                count_next = '0;
            end else begin
                count_next = count_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en          <= ddata_w[0];
            ctrl_auto_reload <= ddata_w[1];
            ctrl_irq_en      <= ddata_w[2];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            compare_q <= '0;
        end else if (wr_compare) begin
            compare_q <= ddata_w;
        end
    end

    // A new match outranks a simultaneous write-1-clear so no event is lost.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            status_match <= 1'b0;
        end else if (match_now) begin
            status_match <= 1'b1;
        end else if (wr_status && ddata_w[0]) begin
            status_match <= 1'b0;
        end
    end

    assign irq = status_match & ctrl_irq_en;

    always_comb begin
        rdata = '0;
        if (hit && MemRead) begin
            case (reg_off)
                OFF_CTRL:    rdata = {{(WIDTH-3){1'b0}}, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
                OFF_COUNT:   rdata = count_q;
                OFF_COMPARE: rdata = compare_q;
                OFF_STATUS:  rdata = {{(WIDTH-1){1'b0}}, status_match};
`ifdef TIMER_PRESCALER_EN
                OFF_PRESC:   rdata = presc_q;
`endif
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, free run, auto-reload, wrap, same-cycle collisions,
// decode corners and the TIMER_PRESCALER_EN option, with hand-computed expectations.
module tb_mmio_timer;

    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_COUNT   = BASE + 32'h04;
    localparam logic [31:0] A_COMPARE = BASE + 32'h08;
    localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
    localparam logic [31:0] A_PRESC   = BASE + 32'h10;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd_val;
    logic [31:0] wrap_exp [6];

    mmio_timer #(.BASE_ADDR(BASE), .WIDTH(32)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .daddr    (daddr),
        .ddata_w  (ddata_w),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .rdata    (rdata),
        .hit      (hit),
        .irq      (irq)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store: driven after the falling edge, committed on the next rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        daddr    = addr;
        ddata_w  = data;
        MemWrite = 1'b1;
        MemRead  = 1'b0;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        daddr   = addr;
        MemRead = 1'b1;
        #1;
        data    = rdata;
        MemRead = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        check(tag, v, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        wrap_exp = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        RESET_N  = 1'b0;
        daddr    = '0;
        ddata_w  = '0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;

        // Reset and idle decode
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_reg($sformatf("reset_off_%0h", i * 4), BASE + 32'(i * 4), 32'd0);
        end
        check("reset_irq", {31'b0, irq}, 32'd0);
        daddr = A_COUNT;
        #1;
        check("hit_in_window", {31'b0, hit}, 32'd1);
        check("rdata_no_read", rdata, 32'd0);
        bus_read(32'h0000_0FFC, rd_val);
        check("miss_rdata", rd_val, 32'd0);
        check("miss_hit", {31'b0, hit}, 32'd0);

        // Free run: the CTRL write edge itself does not tick
        bus_write(A_COMPARE, 32'hFFFF_FFFF);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h1);
        step(10);
        check_reg("free_count", A_COUNT, 32'd10);
        check_reg("free_status", A_STATUS, 32'd0);
        bus_write(A_CTRL, 32'h0);
        check_reg("disable_edge_ticks", A_COUNT, 32'd11);
        step(3);
        check_reg("disabled_hold", A_COUNT, 32'd11);

        // Auto-reload with interrupt
        bus_write(A_COUNT, 32'd0);
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_CTRL, 32'h7);
        step(5);
        check_reg("ar_count5", A_COUNT, 32'd5);
        check("ar_irq_before", {31'b0, irq}, 32'd0);
        step(1);
        check_reg("ar_reload", A_COUNT, 32'd0);
        check_reg("ar_match", A_STATUS, 32'd1);
        check("ar_irq", {31'b0, irq}, 32'd1);
        step(1);
        check_reg("ar_count1", A_COUNT, 32'd1);
        bus_write(A_STATUS, 32'd1);
        check("clr_irq", {31'b0, irq}, 32'd0);
        check_reg("clr_status", A_STATUS, 32'd0);
        check_reg("clr_count", A_COUNT, 32'd2);

        // Wrap past all-ones; match only on the 3 -> 4 tick
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COUNT, 32'hFFFF_FFFE);
        bus_write(A_COMPARE, 32'd3);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_reg($sformatf("wrap_count_%0d", i), A_COUNT, wrap_exp[i]);
            check_reg($sformatf("wrap_status_%0d", i), A_STATUS, (i == 5) ? 32'd1 : 32'd0);
        end
        check("wrap_irq_masked", {31'b0, irq}, 32'd0);

        // STATUS clear colliding with a match: set wins
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'd1);
        check_reg("pre_coll_status", A_STATUS, 32'd0);
        bus_write(A_COMPARE, 32'd8);
        bus_write(A_COUNT, 32'd6);
        bus_write(A_CTRL, 32'h1);
        step(2);
        check_reg("coll_count8", A_COUNT, 32'd8);
        bus_write(A_STATUS, 32'd1);
        check_reg("coll_set_wins", A_STATUS, 32'd1);
        check_reg("coll_count9", A_COUNT, 32'd9);

        // COMPARE write in a match cycle uses the old COMPARE
        bus_write(A_STATUS, 32'd1);
        check_reg("cmp_clr", A_STATUS, 32'd0);
        bus_write(A_COMPARE, 32'd13);
        step(2);
        bus_write(A_COMPARE, 32'd50);
        check_reg("cmp_old_match", A_STATUS, 32'd1);
        check_reg("cmp_count14", A_COUNT, 32'd14);
        check_reg("cmp_new", A_COMPARE, 32'd50);

        // COUNT write overrides the tick
        bus_write(A_COUNT, 32'd100);
        check_reg("cnt_wr_override", A_COUNT, 32'd100);
        step(1);
        check_reg("cnt_after_wr", A_COUNT, 32'd101);

        // IRQ_EN gating and CTRL read-back masking
        bus_write(A_CTRL, 32'h5);
        check("irq_enabled", {31'b0, irq}, 32'd1);
        check_reg("ctrl_rb5", A_CTRL, 32'h5);
        check_reg("ctrl_old_en_tick", A_COUNT, 32'd102);
        bus_write(A_CTRL, 32'hFFFF_FFF9);
        check_reg("ctrl_rb_mask", A_CTRL, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'd0);

        // Decode corners: unmapped offsets, low address bits, out-of-window stores
        bus_write(A_CTRL, 32'h0);
        bus_write(BASE + 32'h14, 32'hAAAA_5555);
        check_reg("unmapped_14", BASE + 32'h14, 32'd0);
        bus_write(BASE + 32'h1C, 32'hFFFF_FFFF);
        check_reg("unmapped_1c", BASE + 32'h1C, 32'd0);
        check_reg("unmapped_no_side", A_COUNT, 32'd104);
        bus_write(BASE + 32'h0B, 32'h1234_5678);
        check_reg("low_bits_ignored", A_COMPARE, 32'h1234_5678);
        bus_write(BASE + 32'h28, 32'hDEAD_BEEF);
        check_reg("outside_ignored", A_COMPARE, 32'h1234_5678);
        bus_read(BASE + 32'h28, rd_val);
        check("outside_rdata", rd_val, 32'd0);

`ifdef TIMER_PRESCALER_EN
        bus_write(A_COUNT, 32'd0);
        bus_write(A_PRESC, 32'd3);
        check_reg("presc_rb", A_PRESC, 32'd3);
        bus_write(A_CTRL, 32'h1);
        step(3);
        check_reg("presc_hold", A_COUNT, 32'd0);
        step(1);
        check_reg("presc_tick1", A_COUNT, 32'd1);
        step(4);
        check_reg("presc_tick2", A_COUNT, 32'd2);
`else
        bus_write(A_PRESC, 32'd3);
        check_reg("presc_absent", A_PRESC, 32'd0);
`endif

        // Reset mid-count overrides a simultaneous store
        bus_write(A_CTRL, 32'h5);
        check("pre_reset_irq", {31'b0, irq}, 32'd1);
        @(negedge CLK);
        RESET_N  = 1'b0;
        daddr    = A_COUNT;
        ddata_w  = 32'h55;
        MemWrite = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        RESET_N  = 1'b1;
        check_reg("rst2_ctrl", A_CTRL, 32'd0);
        check_reg("rst2_count", A_COUNT, 32'd0);
        check_reg("rst2_compare", A_COMPARE, 32'd0);
        check_reg("rst2_status", A_STATUS, 32'd0);
        check_reg("rst2_presc", A_PRESC, 32'd0);
        check("rst2_irq", {31'b0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
